// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/HOLD/HALT fetch stage; imem_req/addr/ack/rdata to memory, instr/pc/instr_valid/instr_ready to decode, pcsrc/pcext/branch_target/jalr_target redirect, suspend/halted/fetch_fault stop, instret count
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        pcsrc,
  input  logic        pcext,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        suspend,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] instret
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] next_pc, target;
  logic hs, bad;
  assign hs = state == HOLD && instr_valid && instr_ready;
  assign target = !pcsrc ? pc + 32'd4 : pcext ? {jalr_target[31:1], 1'b0} : branch_target;
  assign bad = hs && !suspend && |target[1:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? FETCH :
               state == FETCH ? (imem_ack ? HOLD : FETCH) :
               state == HOLD  ? (hs ? (suspend || bad ? HALT : FETCH) : HOLD) : HALT;
  always_comb begin
    imem_req = state == FETCH;
    imem_addr = next_pc;
    halted = state == HALT;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      next_pc <= RESET_PC;
      pc <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      instret <= '0;
    end else begin
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
        pc <= next_pc;
        instr_valid <= 1'b1;
      end
      if (hs) begin
        instret <= instret + 32'd1;
        instr_valid <= 1'b0;
        if (!suspend && !bad) next_pc <= target;
      end
      if (bad) fetch_fault <= 1'b1;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port imem_ack  input  1  memory response valid; imem_rdata sampled in the same cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  held instruction to decode (op, funct3 and funct7 are sliced from it downstream).
REQ-009 SHALL have port instr_valid  output  1  instr and pc are valid.
REQ-010 SHALL have port instr_ready  input  1  decode/execute retires the held instruction this cycle.
REQ-011 SHALL have port pc  output  32  address of the held instruction.
REQ-012 SHALL have port pcsrc  input  1  take the redirect target for the next fetch.
REQ-013 SHALL have port pcext  input  1  with pcsrc high, select jalr_target; otherwise select branch_target.
REQ-014 SHALL have port branch_target  input  32  pc-relative target (branch/jal).
REQ-015 SHALL have port jalr_target  input  32  register-based target (ALU result).
REQ-016 SHALL have port suspend  input  1  retiring instruction halts fetch.
REQ-017 SHALL have port halted  output  1  fetch permanently stopped.
REQ-018 SHALL have port fetch_fault  output  1  misaligned target detected.
REQ-019 SHALL have port instret  output  32  retired-instruction count.

Function
REQ-020 SHALL implement states IDLE, FETCH, HOLD and HALT.
REQ-021 IDLE SHALL go to FETCH on the next clock, unconditionally.
REQ-022 imem_req SHALL be 1 exactly when the state is FETCH, and imem_addr SHALL equal the next-PC register, held stable until imem_ack.
REQ-023 In FETCH, imem_ack SHALL capture imem_rdata into instr, set instr_valid, and move to HOLD; instr_valid rises the cycle after ack.
REQ-024 imem_ack outside FETCH SHALL be ignored; no state or output change.
REQ-025 In HOLD, instr, pc and instr_valid SHALL stay stable until instr_valid and instr_ready are both high (the handshake).
REQ-026 At the handshake, instret SHALL increment by 1, wrapping from 0xFFFF_FFFF to 0, and instr_valid SHALL clear.
REQ-027 At the handshake, the next PC SHALL be selected as follows:
  - pcsrc=0: pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0);
  - pcsrc=1, pcext=0: branch_target;
  - pcsrc=1, pcext=1: jalr_target with bit 0 cleared.
REQ-028 After a handshake without suspend or fault, the state SHALL return to FETCH, so imem_req is high the next cycle with the new address.
REQ-029 If the selected target has bit 1 or bit 0 set after REQ-027, the block SHALL set fetch_fault and go to HALT, and no request SHALL be issued.
REQ-030 suspend=1 at the handshake SHALL take priority over redirect; the block SHALL go to HALT with halted=1.
REQ-031 suspend, pcsrc and pcext SHALL be ignored when there is no handshake.
REQ-032 HALT SHALL be exited only by reset.
REQ-033 In HALT: imem_req=0, instr_valid=0, instret frozen, and pc holding the last retired address.
REQ-034 Minimum throughput SHALL be one instruction per 3 cycles, given ack in the cycle after req and ready in the same cycle as valid.

Reset
REQ-035 While reset_n=0, the block SHALL hold: state=IDLE, next-PC=RESET_PC, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fetch_fault=0, instret=0.
REQ-036 Reset asserted mid-fetch or mid-hold SHALL abandon the outstanding request; an imem_ack for it after reset release SHALL be ignored under REQ-024.
REQ-037 The first imem_req SHALL occur in the second cycle after reset_n rises, with imem_addr=RESET_PC.

Verification
REQ-038 Reset release, ack 1 cycle after req, ready tied high -> addresses 0x0, 0x4, 0x8 fetched; instret=3 after the third handshake.
REQ-039 Ack delayed 5 cycles while imem_rdata toggles -> imem_addr stable throughout, and instr equals the data present on the ack cycle.
REQ-040 pc=0x100 handshake with pcsrc=1, pcext=1, jalr_target=0x201 -> next imem_addr=0x200; with jalr_target=0x202 -> fetch_fault=1, halted state, no imem_req.
REQ-041 Handshake with suspend=1 and pcsrc=1 -> halted=1, imem_req stays 0 for 20 cycles, and instret is frozen.
REQ-042 RESET_PC=0xFFFF_FFFC, sequential flow -> second fetch at 0x0; preload instret=0xFFFF_FFFF (via a bench force) -> wraps to 0.
REQ-043 Assert reset_n low while in FETCH, release, then pulse a stale imem_ack during IDLE -> ack ignored, and the first request goes to RESET_PC.
